div_sp_sched: RTL

- Shares one single-precision divider (div_sp) among N requesters.
- Each requester uses its own valid/ready request channel and valid/ready response channel.
- Arbitration is round-robin. The block pulses the divider's start input, holds the operands stable, and counts a fixed latency before capturing the quotient.
- Sits between the FP compute lanes and the single div_sp instance.

---
 rtl/div_sched_pkg.sv | 23 ++
 rtl/rr_arbiter_n.sv | 27 ++
 rtl/div_sp_sched.sv | 100 ++++++++++
 3 files changed

// File: rtl/div_sched_pkg.sv
// rtl/div_sched_pkg.sv - shared types and helpers for the divider scheduler
package div_sched_pkg;

    localparam int FP_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Width of an index able to address v entries (minimum 1 bit).
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// rtl/rr_arbiter_n.sv - combinational round-robin pick starting at ptr
module rr_arbiter_n
    import div_sched_pkg::*;
#(
    parameter int N  = 4,
    parameter int OW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [OW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [OW-1:0] idx
);

    // Scan from the farthest slot back to ptr so the nearest set request wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                grant = '0;
                grant[(int'(ptr) + k) % N] = 1'b1;
                idx = OW'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/div_sp_sched.sv
// rtl/div_sp_sched.sv - round-robin sharing of one single-precision divider
module div_sp_sched
    import div_sched_pkg::*;
#(
    parameter int N       = 4,
    parameter int DIV_LAT = 24,
    parameter int CW      = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N-1:0]        req_valid,
    output logic [N-1:0]        req_ready,
    input  logic [FP_W*N-1:0]   req_a,
    input  logic [FP_W*N-1:0]   req_b,
    output logic [N-1:0]        rsp_valid,
    input  logic [N-1:0]        rsp_ready,
    output logic [FP_W-1:0]     rsp_z,
    output logic                div_strt,
    output logic [FP_W-1:0]     div_a,
    output logic [FP_W-1:0]     div_b,
    input  logic [FP_W-1:0]     div_z,
    output logic                busy
);

    localparam int OW = clog2(N);

    state_t        state, state_nx;
    logic [OW-1:0] ptr;
    logic [OW-1:0] owner;
    logic [CW-1:0] cnt;
    logic [N-1:0]  gnt;
    logic [OW-1:0] gnt_idx;
    logic          hs;
    logic          last_wait;

    rr_arbiter_n #(.N(N), .OW(OW)) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (gnt),
        .idx   (gnt_idx)
    );

    // The arbiter grants whenever any request is present, so IDLE always handshakes.
    assign hs        = (state == IDLE) && (|req_valid);
    assign last_wait = (state == WAIT) && (cnt == CW'(DIV_LAT - 1));
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        req_ready = '0;
        rsp_valid = '0;
        div_strt  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = gnt;
                if (|req_valid) state_nx = START;
            end
            START: begin
                div_strt = 1'b1;
                state_nx = WAIT;
            end
            WAIT: begin
                if (last_wait) state_nx = RESP;
            end
            RESP: begin
                rsp_valid[owner] = 1'b1;
                if (rsp_ready[owner]) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operands stay registered until the next grant so the divider sees them throughout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr   <= '0;
            owner <= '0;
            cnt   <= '0;
            div_a <= '0;
            div_b <= '0;
            rsp_z <= '0;
        end else begin
            if (hs) begin
                owner <= gnt_idx;
                div_a <= req_a[int'(gnt_idx)*FP_W +: FP_W];
                div_b <= req_b[int'(gnt_idx)*FP_W +: FP_W];
                ptr   <= (gnt_idx == OW'(N - 1)) ? '0 : gnt_idx + 1'b1;
            end
            if (state == START)     cnt <= '0;
            else if (state == WAIT) cnt <= cnt + 1'b1;
            if (last_wait) rsp_z <= div_z;
        end
    end

endmodule
